// File: rtl/ps2_xmt.sv
// ps2_xmt: host-to-device PS/2 transmitter on the I/O bus (two words); PS2_XMT_IRQ_EN adds the completion interrupt
module ps2_xmt #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stb,
   input  logic        we,
   input  logic        addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   output logic        irq,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe
);
   localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                         ((TIMEOUT_CYCLES > REQ_CYCLES) ? TIMEOUT_CYCLES : REQ_CYCLES) :
                         ((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES);
   localparam int CW = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

   state_t        state, state_nx;
   logic          clk_s1, clk_s2, clk_q, dat_s1, dat_s2, fall;
   logic [CW-1:0] cnt, tmo;
   logic [10:0]   shift;
   logic [3:0]    bitcnt;
   logic          busy, done, err, irq_en;
   logic          wr0, wr1, in_xfer, tmo_hit, ack_ev;
   logic          unused_bits;

   assign fall     = clk_q & ~clk_s2;
   assign wr0      = stb & we & ~addr & (state == IDLE);
   assign wr1      = stb & we & addr;
   assign in_xfer  = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
   assign tmo_hit  = in_xfer && (tmo == CW'(TIMEOUT_CYCLES - 1));
   assign ack_ev   = (state == ACK) & fall & ~tmo_hit;
   assign ack      = stb;
   assign data_out = !stb ? 32'b0 : addr ? {30'b0, irq_en, 1'b0} : {29'b0, err, done, busy};
   assign unused_bits = ^{data_in[31:8], data_in[1]};

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = wr0 ? INHIBIT : IDLE;
         INHIBIT:   state_nx = (cnt == CW'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
         REQ:       state_nx = (cnt == CW'(REQ_CYCLES - 1)) ? SHIFT : REQ;
         SHIFT:     state_nx = tmo_hit ? IDLE : (fall && bitcnt == 4'd9) ? ACK : SHIFT;
         ACK:       state_nx = tmo_hit ? IDLE : fall ? WAIT_IDLE : ACK;
         WAIT_IDLE: state_nx = (tmo_hit || (clk_s2 && dat_s2)) ? IDLE : WAIT_IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy        = state != IDLE;
      ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
      ps2_data_oe = (state == REQ) || (state == SHIFT && !shift[0]);
   end

   // shift holds {stop, parity, data, start}; start sits in bit 0 until the first device edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_q  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         cnt    <= '0;
         tmo    <= '0;
         shift  <= '1;
         bitcnt <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         clk_s1 <= ps2_clk_in;
         clk_s2 <= clk_s1;
         clk_q  <= clk_s2;
         dat_s1 <= ps2_data_in;
         dat_s2 <= dat_s1;
         cnt    <= (state_nx != state) ? '0 : cnt + 1'b1;
         tmo    <= in_xfer ? tmo + 1'b1 : '0;
         if (wr0) shift <= {1'b1, ~^data_in[7:0], data_in[7:0], 1'b0};
         else if (state == SHIFT && fall) shift <= {1'b1, shift[10:1]};
         bitcnt <= (state != SHIFT) ? 4'd0 : bitcnt + {3'b0, fall};
         if (wr0 || (wr1 && data_in[0])) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (ack_ev && !dat_s2) done <= 1'b1;
         if ((ack_ev && dat_s2) || tmo_hit) err <= 1'b1;
      end
   end

`ifdef PS2_XMT_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr1) irq_en <= data_in[1];
         irq <= irq_en & (done | err);
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_xmt.sv
// tb_ps2_xmt: directed vectors against a clocking PS/2 device model with shortened timing parameters
module tb_ps2_xmt;
   localparam int INH   = 400;
   localparam int RQ    = 20;
   localparam int TO    = 8000;
   localparam int HP    = 50;
   localparam int BOUND = 20000;

   logic        clk, rst, stb, we, addr;
   logic [31:0] data_in, data_out;
   logic        ack, irq, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic        dev_clk, dev_data;
   int          checks, passes;

   typedef struct {
      logic [7:0]  b;
      bit          dev_ack;
      bit          clr;
      logic [10:0] frame;
      logic [31:0] status;
   } vec_t;

   vec_t vecs[5];

   ps2_xmt #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
      .data_out(data_out), .ack(ack), .irq(irq), .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got no finish, required finish before 90000 cycles");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic wr(input logic a, input logic [31:0] d);
      @(negedge clk);
      stb = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic a, output logic [31:0] v);
      @(negedge clk);
      stb = 1'b1; we = 1'b0; addr = a;
      #1 v = data_out;
      stb = 1'b0;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int n;
      n = 0;
      rd(1'b0, s);
      while (s[0] && n < BOUND) begin
         rd(1'b0, s);
         n++;
      end
      chk("idle_wait", {31'b0, s[0]}, 32'b0);
   endtask

   // device side: measures the inhibit, then clocks 11 pulses sampling the line while clock is low
   task automatic run_dev(input bit do_ack, input bit clr, input int rst_at,
                          output logic [10:0] frame, output int inh, output int req_n);
      int t;
      frame = '1; inh = 0; req_n = 0; t = 0;
      while (ps2_clk_oe && t < BOUND) begin
         inh++;
         if (ps2_data_oe) req_n++;
         @(negedge clk);
         t++;
      end
      repeat (HP) @(negedge clk);
      frame[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) dev_data = ~do_ack;
         dev_clk = 1'b0;
         if (k == rst_at) begin
            repeat (3) @(negedge clk);
            chk("pre_rst_data_oe", {31'b0, ps2_data_oe}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            stb = 1'b1; we = 1'b0; addr = 1'b0;
            #1;
            chk("rst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'b0);
            chk("rst_status", data_out, 32'b0);
            stb = 1'b0; rst = 1'b0; dev_clk = 1'b1;
            repeat (HP) @(negedge clk);
            return;
         end
         if (k == 11 && clr) begin
            repeat (2) @(negedge clk);
            stb = 1'b1; we = 1'b1; addr = 1'b1; data_in = 32'h1;
            @(negedge clk);
            stb = 1'b0; we = 1'b0;
            repeat (HP - 3) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         if (k <= 10) frame[k] = ps2_data_in;
         dev_clk = 1'b1;
         repeat (HP) @(negedge clk);
         if (k == 11) dev_data = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] s;
      logic [10:0] fr;
      int inh, rq, n;
      checks = 0; passes = 0;
      vecs[0] = '{8'hF4, 1'b1, 1'b0, 11'b10111101000, 32'h2};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 11'b11000000000, 32'h4};
      vecs[2] = '{8'h01, 1'b1, 1'b1, 11'b10000000010, 32'h2};
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 11'b11111111110, 32'h2};
      vecs[4] = '{8'h12, 1'b0, 1'b0, 11'b11000100100, 32'h4};
      rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
      dev_clk = 1'b1; dev_data = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'b0);
      chk("reset_irq", {31'b0, irq}, 32'b0);
      chk("nostb_read", data_out, 32'b0);
      chk("nostb_ack", {31'b0, ack}, 32'b0);
      stb = 1'b1;
      #1 chk("stb_ack", {31'b0, ack}, 32'd1);
      stb = 1'b0;
      rd(1'b0, s); chk("reset_status", s, 32'b0);
      rd(1'b1, s); chk("reset_ctrl", s, 32'b0);

      for (int i = 0; i < 5; i++) begin
         wr(1'b0, {24'b0, vecs[i].b});
         run_dev(vecs[i].dev_ack, vecs[i].clr, 0, fr, inh, rq);
         chk("inhibit_len", inh, INH + RQ);
         chk("req_len", rq, RQ);
         chk("frame", {21'b0, fr}, {21'b0, vecs[i].frame});
         wait_idle();
         rd(1'b0, s); chk("status", s, vecs[i].status);
      end
      @(negedge clk);
      #1 chk("nostb_after_err", data_out, 32'b0);

      wr(1'b0, 32'hF4);
      rd(1'b0, s); chk("busy_status", s, 32'h1);
      wr(1'b0, 32'h12);
      rd(1'b0, s); chk("busy_write_status", s, 32'h1);
      run_dev(1'b1, 1'b0, 0, fr, inh, rq);
      chk("busy_write_frame", {21'b0, fr}, {21'b0, 11'b10111101000});
      wait_idle();
      rd(1'b0, s); chk("busy_write_done", s, 32'h2);

      wr(1'b0, 32'hFF);
      stb = 1'b1; we = 1'b0; addr = 1'b0;
      #1 n = 0;
      while (data_out[0] && n < BOUND) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("timeout_cycles", n, INH + RQ + TO);
      chk("timeout_status", data_out, 32'h4);
      chk("timeout_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'b0);
      stb = 1'b0;

      wr(1'b0, 32'h00);
      run_dev(1'b1, 1'b0, 5, fr, inh, rq);
      wr(1'b0, 32'hF4);
      run_dev(1'b1, 1'b0, 0, fr, inh, rq);
      chk("post_rst_frame", {21'b0, fr}, {21'b0, 11'b10111101000});
      wait_idle();
      rd(1'b0, s); chk("post_rst_status", s, 32'h2);

      wr(1'b1, 32'h2);
      rd(1'b1, s);
`ifdef PS2_XMT_IRQ_EN
      chk("irq_en_read", s, 32'h2);
`else
      chk("irq_en_read", s, 32'h0);
`endif
      wr(1'b0, 32'hF4);
      run_dev(1'b1, 1'b0, 0, fr, inh, rq);
      wait_idle();
`ifdef PS2_XMT_IRQ_EN
      chk("irq_set", {31'b0, irq}, 32'd1);
`else
      chk("irq_tied", {31'b0, irq}, 32'd0);
`endif
      wr(1'b1, 32'h1);
      @(negedge clk);
      chk("irq_clear", {31'b0, irq}, 32'd0);
      rd(1'b0, s); chk("clear_status", s, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
